uart_rx_peripheral_top: RTL and testbench
=========================================

UART_RX_PERIPHERAL_TOP -- requirements
Module: uart_rx_peripheral_top

Interface
REQ-001 Parameter FIFO_DEPTH, default 256: receive FIFO entries; power of two, at least 2.
REQ-002 Parameter BAUD_RATE, default 115200: line bit rate.
REQ-003 Parameter CLK_FREQ, default 50000000: clock frequency in Hz.
REQ-004 Parameter PAR_EN, default 1: 1 = parity bit expected after data.
REQ-005 Parameter PAR_TYPE, default 0: 0 = even parity, 1 = odd parity.
REQ-006 Port i_uart_clk, input, 1: the block's one clock.
REQ-007 Port i_uart_rst, input, 1: reset; synchronous, active-high.
REQ-008 Port i_uart_rx_sdata, input, 1: serial line, asynchronous; idle high.
REQ-009 Port i_uart_rx_rden, input, 1: core pops FIFO head this cycle.
REQ-010 Port i_uart_rx_err_clr, input, 1: clears sticky error flags.
REQ-011 Port o_uart_rx_pdata, output, 8: FIFO head byte (first-word fall-through).
REQ-012 Port o_uart_rx_valid, output, 1: FIFO not empty.
REQ-013 Port o_uart_rx_fifo_full, output, 1: FIFO full.
REQ-014 Port o_uart_rx_par_err, output, 1: sticky parity error.
REQ-015 Port o_uart_rx_frm_err, output, 1: sticky framing error.
REQ-016 Port o_uart_rx_overrun, output, 1: sticky overrun (byte lost because FIFO full).

Function
REQ-017 Sampling: i_uart_rx_sdata passes through a 2-flop synchronizer; both flops reset to 1.
REQ-018 Oversampling tick: asserted every BAUD_DIV = CLK_FREQ/(BAUD_RATE*16) clocks; 16 ticks per bit.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE -> START: on a synchronized falling edge; tick counter restarts.
REQ-021 START: samples at tick 7. Line high = false start, return to IDLE with no flag. Line low = go to DATA.
REQ-022 DATA: samples 8 bits at tick 7 of each bit, LSB first.
REQ-023 DATA exit: after bit 7, go to PARITY if PAR_EN=1, else to STOP.
REQ-024 PARITY: samples the parity bit; mismatch against PAR_TYPE marks the frame bad-parity.
REQ-025 STOP: samples at tick 7, then returns to IDLE immediately; the remaining half-bit is used for next-start detection.
REQ-026 Stop sample 0: byte discarded; o_uart_rx_frm_err set.
REQ-027 Bad parity with a valid stop: byte discarded; o_uart_rx_par_err set.
REQ-028 Good frame: byte pushed to the FIFO in the stop-sample cycle.
REQ-029 Good frame with FIFO full and no pop that cycle: byte dropped; o_uart_rx_overrun set.
REQ-030 Push and pop in the same cycle while full: both succeed; occupancy unchanged.
REQ-031 Pop and push in the same cycle while not full/empty: occupancy unchanged.
REQ-032 i_uart_rx_rden while empty: ignored; no pointer change.
REQ-033 Pop latency: o_uart_rx_pdata shows the next entry on the cycle after the pop; a byte pushed into an empty FIFO is visible with o_uart_rx_valid=1 on the next cycle.
REQ-034 Pointers: wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.
REQ-035 Sticky flags: clear only on i_uart_rx_err_clr or reset. Set wins over clear when both occur in the same cycle.

Reset
REQ-036 Reset state: FSM in IDLE; tick, bit and baud counters zero; FIFO empty.
REQ-037 Output values during reset: o_uart_rx_valid=0, o_uart_rx_fifo_full=0, all error flags 0, o_uart_rx_pdata=0.
REQ-038 Reset mid-frame: the partial frame is abandoned; no push and no flag.

Configuration
REQ-039 Macro UART_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of samples at ticks 6, 7 and 8; the decision is made at tick 8.
REQ-040 Macro UART_RX_MAJORITY_EN undefined: single sample at tick 7.

Structure
REQ-041 Package uart_pkg holds the rx state enum, OVERSAMPLE=16 and the sample-tick constants.
REQ-042 Sub-module uart_rx_fifo: synchronous FWFT FIFO (push, pop, full, empty, data).

Verification
All scenarios use CLK_FREQ=1843200 and BAUD_RATE=115200, giving BAUD_DIV=1 (16 clocks per bit).
REQ-043 Frame 0x55 with even parity bit 0 and stop bit 1 -> o_uart_rx_valid=1 and o_uart_rx_pdata=0x55; no error flags.
REQ-044 Frame 0xA3 with parity bit 1 (wrong, PAR_TYPE=0) -> no push; o_uart_rx_par_err=1; pulse i_uart_rx_err_clr -> flag back to 0.
REQ-045 Frame 0x0F with stop bit 0 -> no push; o_uart_rx_frm_err=1.
REQ-046 Low glitch of 4 clocks on idle line -> FSM back in IDLE; no push, no flags.
REQ-047 FIFO_DEPTH=4; send 5 frames 0x01..0x05 without reads -> o_uart_rx_fifo_full=1 and o_uart_rx_overrun=1; four pops return 0x01..0x04 in order.
REQ-048 Assert i_uart_rst at data bit 3 of a frame, then send frame 0x7E -> only 0x7E is received; no flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared receiver definitions: FSM state type, oversampling rate and sample-point tick numbers.
package uart_pkg;

  localparam int OVERSAMPLE      = 16;
  localparam int TICK_W          = $clog2(OVERSAMPLE);
  localparam int MAJ_FIRST_TICK  = 6;
  localparam int SAMPLE_TICK     = 7;
  localparam int MAJ_DECIDE_TICK = 8;
  localparam int LAST_TICK       = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO; the head is valid combinationally whenever not empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_peripheral_top.sv
// UART receiver with 16x oversampling, optional parity, sticky error flags and a receive FIFO.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote of ticks 6/7/8.
//
// state     | meaning
// RX_IDLE   | line idle, waiting for a synchronized falling edge
// RX_START  | checking the start bit at mid-bit, false starts return to idle
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | sampling the parity bit and recording a mismatch
// RX_STOP   | sampling the stop bit, then push or flag the frame
module uart_rx_peripheral_top
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 256,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 50000000,
  parameter int PAR_EN     = 1,
  parameter int PAR_TYPE   = 0
) (
  input  logic       i_uart_clk,
  input  logic       i_uart_rst,
  input  logic       i_uart_rx_sdata,
  input  logic       i_uart_rx_rden,
  input  logic       i_uart_rx_err_clr,
  output logic [7:0] o_uart_rx_pdata,
  output logic       o_uart_rx_valid,
  output logic       o_uart_rx_fifo_full,
  output logic       o_uart_rx_par_err,
  output logic       o_uart_rx_frm_err,
  output logic       o_uart_rx_overrun
);

  localparam int   BAUD_DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int   BAUD_DIV     = (BAUD_DIV_RAW < 1) ? 1 : BAUD_DIV_RAW;
  localparam int   BAUD_W       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic PAR_ODD      = (PAR_TYPE != 0);

  rx_state_t         state;
  rx_state_t         state_nxt;
  logic              rx_sync1;
  logic              rx_sync2;
  logic              rx_prev;
  logic              falling;
  logic [BAUD_W-1:0] baud_cnt;
  logic              tick;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              par_bad;
  logic              bit_val;
  logic              decide;
  logic              bit_end;
  logic              push_req;
  logic              par_set;
  logic              frm_set;
  logic              ovr_set;
  logic              par_err;
  logic              frm_err;
  logic              overrun;
  logic              fifo_full;
  logic              fifo_empty;

  always_ff @(posedge i_uart_clk) begin
    if (i_uart_rst) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= i_uart_rx_sdata;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  assign falling = rx_prev & ~rx_sync2;

  // Baud divider is held preloaded while idle so bit timing starts from the detected edge.
  always_ff @(posedge i_uart_clk) begin
    if (i_uart_rst) begin
      baud_cnt <= '0;
    end else if (state == RX_IDLE || baud_cnt == '0) begin
      baud_cnt <= BAUD_W'(BAUD_DIV - 1);
    end else begin
      baud_cnt <= baud_cnt - BAUD_W'(1);
    end
  end

  assign tick    = (state != RX_IDLE) && (baud_cnt == '0);
  assign bit_end = tick && (tick_cnt == TICK_W'(LAST_TICK));

`ifdef UART_RX_MAJORITY_EN
  logic samp_a;
  logic samp_b;

  always_ff @(posedge i_uart_clk) begin
    if (i_uart_rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (tick) begin
      if (tick_cnt == TICK_W'(MAJ_FIRST_TICK)) samp_a <= rx_sync2;
      if (tick_cnt == TICK_W'(SAMPLE_TICK))    samp_b <= rx_sync2;
    end
  end

  assign bit_val = maj3(samp_a, samp_b, rx_sync2);
  assign decide  = tick && (tick_cnt == TICK_W'(MAJ_DECIDE_TICK));
`else
  assign bit_val = rx_sync2;
  assign decide  = tick && (tick_cnt == TICK_W'(SAMPLE_TICK));
`endif

  always_ff @(posedge i_uart_clk) begin
    if (i_uart_rst) state <= RX_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    par_set   = 1'b0;
    frm_set   = 1'b0;
    case (state)
      RX_IDLE: begin
        if (falling) state_nxt = RX_START;
      end
      RX_START: begin
        if (decide && bit_val) state_nxt = RX_IDLE;
        else if (bit_end)      state_nxt = RX_DATA;
      end
      RX_DATA: begin
        if (bit_end && bit_cnt == 3'd7) state_nxt = (PAR_EN != 0) ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: begin
        if (bit_end) state_nxt = RX_STOP;
      end
      RX_STOP: begin
        // Leave immediately after the stop decision; the rest of the stop bit hunts for the next start.
        if (decide) begin
          state_nxt = RX_IDLE;
          if (!bit_val)     frm_set  = 1'b1;
          else if (par_bad) par_set  = 1'b1;
          else              push_req = 1'b1;
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_uart_clk) begin
    if (i_uart_rst) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bad  <= 1'b0;
    end else begin
      if (state == RX_IDLE) tick_cnt <= '0;
      else if (tick)        tick_cnt <= tick_cnt + TICK_W'(1);
      case (state)
        RX_IDLE: begin
          bit_cnt <= '0;
          par_bad <= 1'b0;
        end
        RX_DATA: begin
          if (decide)  shift   <= {bit_val, shift[7:1]};
          if (bit_end) bit_cnt <= bit_cnt + 3'(1);
        end
        RX_PARITY: begin
          if (decide) par_bad <= ((^shift) ^ bit_val) != PAR_ODD;
        end
        default: ;
      endcase
    end
  end

  assign ovr_set = push_req & fifo_full & ~i_uart_rx_rden;

  always_ff @(posedge i_uart_clk) begin
    if (i_uart_rst) begin
      par_err <= 1'b0;
      frm_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      par_err <= par_set | (par_err & ~i_uart_rx_err_clr);
      frm_err <= frm_set | (frm_err & ~i_uart_rx_err_clr);
      overrun <= ovr_set | (overrun & ~i_uart_rx_err_clr);
    end
  end

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (i_uart_clk),
    .rst   (i_uart_rst),
    .push  (push_req),
    .wdata (shift),
    .pop   (i_uart_rx_rden),
    .rdata (o_uart_rx_pdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_uart_rx_valid     = ~fifo_empty;
  assign o_uart_rx_fifo_full = fifo_full;
  assign o_uart_rx_par_err   = par_err;
  assign o_uart_rx_frm_err   = frm_err;
  assign o_uart_rx_overrun   = overrun;

endmodule

// File: tb/tb_uart_rx_peripheral_top.sv
// Self-checking bench for uart_rx_peripheral_top: directed table, corner sequences, random frames vs a frame-level model.
module tb_uart_rx_peripheral_top;

  localparam int   DEPTH    = 4;
  localparam logic PAR_TYPE = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic       sdata;
  logic       rden;
  logic       err_clr;
  logic [7:0] pdata;
  logic       valid;
  logic       full;
  logic       par_err;
  logic       frm_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic       m_par;
  logic       m_frm;
  logic       m_ovr;

  typedef struct {
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic       exp_valid;
    logic [7:0] exp_pdata;
    logic       exp_par;
    logic       exp_frm;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  uart_rx_peripheral_top #(
    .FIFO_DEPTH (DEPTH),
    .BAUD_RATE  (115200),
    .CLK_FREQ   (1843200),
    .PAR_EN     (1),
    .PAR_TYPE   (0)
  ) dut (
    .i_uart_clk          (clk),
    .i_uart_rst          (rst),
    .i_uart_rx_sdata     (sdata),
    .i_uart_rx_rden      (rden),
    .i_uart_rx_err_clr   (err_clr),
    .o_uart_rx_pdata     (pdata),
    .o_uart_rx_valid     (valid),
    .o_uart_rx_fifo_full (full),
    .o_uart_rx_par_err   (par_err),
    .o_uart_rx_frm_err   (frm_err),
    .o_uart_rx_overrun   (overrun)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic good_parity(input logic [7:0] d);
    return (^d) ^ PAR_TYPE;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    sdata = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      sdata = d[i];
      step(16);
    end
    sdata = p;
    step(16);
    sdata = s;
    step(16);
    sdata = 1'b1;
    step(4);
  endtask

  // Frame-level behaviour: what one received frame does to the FIFO contents and flags.
  task automatic model_frame(input logic [7:0] d, input logic p, input logic s);
    if (!s)                          m_frm = 1'b1;
    else if (p != good_parity(d))    m_par = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(d);
    else                             m_ovr = 1'b1;
  endtask

  task automatic model_reset();
    model_q.delete();
    m_par = 1'b0;
    m_frm = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (model_q.size() > 0) ? model_q[0] : 8'h00;
    check({tag, " valid"}, valid, model_q.size() > 0);
    check({tag, " pdata"}, pdata, head);
    check({tag, " full"}, full, model_q.size() == DEPTH);
    check({tag, " par_err"}, par_err, m_par);
    check({tag, " frm_err"}, frm_err, m_frm);
    check({tag, " overrun"}, overrun, m_ovr);
  endtask

  task automatic pop_one();
    rden = 1'b1;
    step(1);
    rden = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    m_par = 1'b0;
    m_frm = 1'b0;
    m_ovr = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;

    vecs[0] = '{8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h0F, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

    rst     = 1'b1;
    sdata   = 1'b1;
    rden    = 1'b0;
    err_clr = 1'b0;
    model_reset();
    step(3);
    check_state("reset");
    rst = 1'b0;
    step(2);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].par_bit, vecs[i].stop_bit);
      check($sformatf("vec%0d valid", i), valid, vecs[i].exp_valid);
      check($sformatf("vec%0d pdata", i), pdata, vecs[i].exp_pdata);
      check($sformatf("vec%0d par_err", i), par_err, vecs[i].exp_par);
      check($sformatf("vec%0d frm_err", i), frm_err, vecs[i].exp_frm);
      check($sformatf("vec%0d overrun", i), overrun, 0);
      if (vecs[i].exp_valid) pop_one();
      clear_flags();
      check($sformatf("vec%0d cleared par", i), par_err, 0);
      check($sformatf("vec%0d cleared frm", i), frm_err, 0);
      check($sformatf("vec%0d drained", i), valid, 0);
    end
    model_reset();

    // Pop on empty must not move the pointers.
    pop_one();
    send_frame(8'h3C, good_parity(8'h3C), 1'b1);
    model_frame(8'h3C, good_parity(8'h3C), 1'b1);
    check_state("empty_pop");
    pop_one();
    check_state("empty_pop drained");

    // Short low glitch is a false start; the receiver must accept the next frame normally.
    sdata = 1'b0;
    step(4);
    sdata = 1'b1;
    step(30);
    check_state("glitch");
    send_frame(8'hC5, good_parity(8'hC5), 1'b1);
    model_frame(8'hC5, good_parity(8'hC5), 1'b1);
    check_state("after_glitch");
    pop_one();

    // Fill past capacity: fifth byte is dropped and flagged.
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(d, good_parity(d), 1'b1);
      model_frame(d, good_parity(d), 1'b1);
    end
    check_state("overrun");
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovr head%0d", i), pdata, i);
      pop_one();
      check_state($sformatf("ovr pop%0d", i));
    end
    clear_flags();

    // Reset in the middle of data bit 3; FIFO content and flags are also discarded.
    send_frame(8'h11, good_parity(8'h11), 1'b1);
    send_frame(8'h22, good_parity(8'h22), 1'b0);
    d = 8'hB6;
    sdata = 1'b0;
    step(16);
    for (int i = 0; i < 3; i++) begin
      sdata = d[i];
      step(16);
    end
    sdata = d[3];
    step(8);
    rst = 1'b1;
    step(1);
    model_reset();
    check_state("in_reset");
    sdata = 1'b1;
    step(1);
    rst = 1'b0;
    step(20);
    check_state("post_reset idle");
    send_frame(8'h7E, good_parity(8'h7E), 1'b1);
    model_frame(8'h7E, good_parity(8'h7E), 1'b1);
    check_state("post_reset frame");
    pop_one();
    check_state("post_reset drained");

    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 5) == 0) ? ~good_parity(d) : good_parity(d);
      s = ($urandom_range(0, 7) != 0);
      send_frame(d, p, s);
      model_frame(d, p, s);
      check_state($sformatf("rand%0d", n));
      if (model_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        pop_one();
        check_state($sformatf("rand%0d pop", n));
      end
      if ($urandom_range(0, 3) == 0) begin
        clear_flags();
        check_state($sformatf("rand%0d clr", n));
      end
    end

    while (model_q.size() > 0) begin
      pop_one();
      check_state("final drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
